uart_tx_gen: RTL and testbench

UART_TX_GEN -- requirements
Module: uart_tx_gen

---
 rtl/uart_tx_gen.sv | 262 ++++++++++++++++++++++++++
 tb/tb_uart_tx_gen.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_gen.sv
// uart_tx_gen: UART transmitter with a byte FIFO in front of a framing FSM.
//
// Parameters
//   DEPTH       TX FIFO entries (power of 2, >= 4)
//   OSR         bclk ticks per serial bit (2..256)
//
// Ports
//   clk         system clock, rising edge
//   resetn      asynchronous active-low reset
//   bclk        baud tick enable, one clk wide per tick
//   wr_data     byte to enqueue (only the low char_len+5 bits are sent)
//   wr_en       enqueue request, accepted whenever the FIFO is not full
//   char_len    data length code: 0..3 -> 5..8 bits
//   parity_en   parity bit enable
//   parity_type 1 = even, 0 = odd
//   stop2       1 = two stop bits
//   tx_en       permits new frames to start
//   break_en    line break request (txd forced low while idle)
//   thr_val     FIFO threshold select: DEPTH/2, DEPTH/4, DEPTH/8, 0
//   txd         registered serial line, idle high
//   tx_busy     frame in progress
//   tx_bclk_en  baud generator enable (tx_busy | break_en)
//   fifo_level  occupied FIFO entries
//   fifo_full   FIFO full
//   tx_thr      fifo_level at or below the selected threshold
//   tx_empty    FIFO empty and FSM idle
//   ovf         one-clk pulse when a write is dropped because the FIFO is full
module uart_tx_gen #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned OSR   = 16
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     bclk,
    input  logic [7:0]               wr_data,
    input  logic                     wr_en,
    input  logic [1:0]               char_len,
    input  logic                     parity_en,
    input  logic                     parity_type,
    input  logic                     stop2,
    input  logic                     tx_en,
    input  logic                     break_en,
    input  logic [1:0]               thr_val,
    output logic                     txd,
    output logic                     tx_busy,
    output logic                     tx_bclk_en,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     fifo_full,
    output logic                     tx_thr,
    output logic                     tx_empty,
    output logic                     ovf
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = (OSR > 1) ? $clog2(OSR) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop
    } state_e;

    // ------------------------------------------------------------------
    // FIFO
    // ------------------------------------------------------------------
    logic [7:0]    mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic          ovf_q;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [7:0]    head;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    // Same slot, opposite lap: only the extra MSB differs.
    assign fifo_full  = ((wr_ptr_q ^ rd_ptr_q) == {1'b1, {AW{1'b0}}});
    assign push       = wr_en & ~fifo_full;
    assign head       = mem_q[rd_ptr_q[AW-1:0]];
    // Pointer difference stays exact on simultaneous push and pop.
    assign fifo_level = wr_ptr_q - rd_ptr_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PW'(1);
            end
            ovf_q <= wr_en & fifo_full;
        end
    end

    assign ovf = ovf_q;

    always_comb begin
        tx_thr = 1'b0;
        case (thr_val)
            2'b00: tx_thr = (fifo_level <= PW'(DEPTH / 2));
            2'b01: tx_thr = (fifo_level <= PW'(DEPTH / 4));
            2'b10: tx_thr = (fifo_level <= PW'(DEPTH / 8));
            2'b11: tx_thr = (fifo_level == '0);
            default: tx_thr = 1'b0;
        endcase
    end

    // ------------------------------------------------------------------
    // Framing FSM
    // ------------------------------------------------------------------
    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    bit_q, bit_d;
    logic          stop_q, stop_d;
    logic [7:0]    shift_q, shift_d;
    logic [1:0]    len_q, len_d;
    logic          par_en_q, par_en_d;
    logic          par_q, par_d;
    logic          stop2_q, stop2_d;
    logic          txd_q, txd_d;

    logic          tick_done;
    logic          start_ok;
    logic [7:0]    load_data;

    assign tick_done = bclk && (cnt_q == CW'(OSR - 1));
    assign start_ok  = tx_en & ~break_en & ~fifo_empty;
    // Unused high bits are cleared so parity covers only transmitted bits.
    assign load_data = head & (8'hFF >> (2'd3 - char_len));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        bit_d    = bit_q;
        stop_d   = stop_q;
        shift_d  = shift_q;
        len_d    = len_q;
        par_en_d = par_en_q;
        par_d    = par_q;
        stop2_d  = stop2_q;
        txd_d    = txd_q;
        pop      = 1'b0;

        if (bclk) begin
            cnt_d = tick_done ? '0 : cnt_q + CW'(1);
        end

        unique case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (start_ok) begin
                    pop     = 1'b1;
                    state_d = StStart;
                end
            end
            StStart: begin
                if (tick_done) begin
                    state_d = StData;
                    bit_d   = '0;
                end
            end
            StData: begin
                if (tick_done) begin
                    shift_d = shift_q >> 1;
                    if (bit_q == ({1'b0, len_q} + 3'd4)) begin
                        state_d = par_en_q ? StParity : StStop;
                        stop_d  = 1'b0;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            StParity: begin
                if (tick_done) begin
                    state_d = StStop;
                    stop_d  = 1'b0;
                end
            end
            StStop: begin
                if (tick_done) begin
                    if (stop2_q && !stop_q) begin
                        stop_d = 1'b1;
                    end else if (start_ok) begin
                        // Back-to-back: next start bit follows the stop bit directly.
                        pop     = 1'b1;
                        state_d = StStart;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase

        if (pop) begin
            shift_d  = load_data;
            len_d    = char_len;
            par_en_d = parity_en;
            par_d    = (^load_data) ^ ~parity_type;
            stop2_d  = stop2;
        end

        if (state_d != state_q) begin
            cnt_d = '0;
        end

        // txd is registered from the next state so it moves with the FSM.
        unique case (state_d)
            StIdle:   txd_d = ~break_en;
            StStart:  txd_d = 1'b0;
            StData:   txd_d = shift_d[0];
            StParity: txd_d = par_q;
            StStop:   txd_d = 1'b1;
            default:  txd_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            bit_q    <= '0;
            stop_q   <= 1'b0;
            shift_q  <= '0;
            len_q    <= '0;
            par_en_q <= 1'b0;
            par_q    <= 1'b0;
            stop2_q  <= 1'b0;
            txd_q    <= 1'b1;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            bit_q    <= bit_d;
            stop_q   <= stop_d;
            shift_q  <= shift_d;
            len_q    <= len_d;
            par_en_q <= par_en_d;
            par_q    <= par_d;
            stop2_q  <= stop2_d;
            txd_q    <= txd_d;
        end
    end

    assign txd        = txd_q;
    assign tx_busy    = (state_q != StIdle);
    assign tx_bclk_en = tx_busy | break_en;
    assign tx_empty   = fifo_empty & ~tx_busy;

endmodule

// File: tb/tb_uart_tx_gen.sv
// Directed testbench for uart_tx_gen (DEPTH=16, OSR=16).
module tb_uart_tx_gen;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned OSR   = 16;

    logic       clk = 1'b0;
    logic       resetn;
    logic       bclk;
    logic [7:0] wr_data;
    logic       wr_en;
    logic [1:0] char_len;
    logic       parity_en;
    logic       parity_type;
    logic       stop2;
    logic       tx_en;
    logic       break_en;
    logic [1:0] thr_val;
    logic       txd;
    logic       tx_busy;
    logic       tx_bclk_en;
    logic [4:0] fifo_level;
    logic       fifo_full;
    logic       tx_thr;
    logic       tx_empty;
    logic       ovf;

    int checks = 0;
    int errors = 0;
    int bad;

    uart_tx_gen #(
        .DEPTH(DEPTH),
        .OSR  (OSR)
    ) dut (
        .clk        (clk),
        .resetn     (resetn),
        .bclk       (bclk),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .char_len   (char_len),
        .parity_en  (parity_en),
        .parity_type(parity_type),
        .stop2      (stop2),
        .tx_en      (tx_en),
        .break_en   (break_en),
        .thr_val    (thr_val),
        .txd        (txd),
        .tx_busy    (tx_busy),
        .tx_bclk_en (tx_bclk_en),
        .fifo_level (fifo_level),
        .fifo_full  (fifo_full),
        .tx_thr     (tx_thr),
        .tx_empty   (tx_empty),
        .ovf        (ovf)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        wr_data = d;
        wr_en   = 1'b1;
        step();
        wr_en   = 1'b0;
    endtask

    // Advance until the start bit appears; an expired bound fails the check.
    task automatic wait_start(input string tag);
        int n = 0;
        while (txd !== 1'b0 && n < 400) begin
            step();
            n++;
        end
        chk({tag, " start"}, {31'd0, txd}, 32'd0);
    endtask

    // Called on the sample right after the edge that began the start bit.
    // bits[0] is the first bit on the line; each bit must last exactly OSR clks.
    task automatic expect_frame(input string tag, input logic [11:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s bit%0d first", tag, i), {31'd0, txd}, {31'd0, bits[i]});
            repeat (OSR - 1) step();
            chk($sformatf("%s bit%0d last", tag, i), {31'd0, txd}, {31'd0, bits[i]});
            chk($sformatf("%s bit%0d busy", tag, i), {31'd0, tx_busy}, 32'd1);
            step();
        end
    endtask

    function automatic logic [11:0] f8n1(input logic [7:0] d);
        return {3'b001, d, 1'b0};
    endfunction

    initial begin
        resetn      = 1'b0;
        bclk        = 1'b1;
        wr_data     = 8'h00;
        wr_en       = 1'b0;
        char_len    = 2'b11;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        stop2       = 1'b0;
        tx_en       = 1'b0;
        break_en    = 1'b0;
        thr_val     = 2'b00;

        // Reset values
        #12;
        chk("rst txd", {31'd0, txd}, 32'd1);
        chk("rst busy", {31'd0, tx_busy}, 32'd0);
        chk("rst bclk_en", {31'd0, tx_bclk_en}, 32'd0);
        chk("rst level", {27'd0, fifo_level}, 32'd0);
        chk("rst full", {31'd0, fifo_full}, 32'd0);
        chk("rst empty", {31'd0, tx_empty}, 32'd1);
        chk("rst ovf", {31'd0, ovf}, 32'd0);
        chk("rst thr", {31'd0, tx_thr}, 32'd1);
        resetn = 1'b1;
        step();

        // 8N1, 0x55
        push_byte(8'h55);
        chk("55 level", {27'd0, fifo_level}, 32'd1);
        chk("55 empty", {31'd0, tx_empty}, 32'd0);
        thr_val = 2'b11;
        #1;
        chk("thr3 lvl1", {31'd0, tx_thr}, 32'd0);
        thr_val = 2'b00;
        tx_en = 1'b1;
        wait_start("55");
        expect_frame("55", f8n1(8'h55), 10);
        chk("55 busy end", {31'd0, tx_busy}, 32'd0);
        chk("55 txd end", {31'd0, txd}, 32'd1);
        chk("55 empty end", {31'd0, tx_empty}, 32'd1);

        // 5 bits, even parity, 2 stop; config changed mid-frame must not matter
        char_len    = 2'b00;
        parity_en   = 1'b1;
        parity_type = 1'b1;
        stop2       = 1'b1;
        push_byte(8'h07);
        wait_start("07");
        char_len    = 2'b11;
        parity_en   = 1'b0;
        parity_type = 1'b0;
        stop2       = 1'b0;
        expect_frame("07", 12'b0001_1100_1110, 9);
        chk("07 busy end", {31'd0, tx_busy}, 32'd0);

        // 7 bits, odd parity, 1 stop; bit 7 of 0xB3 must not be sent
        char_len    = 2'b10;
        parity_en   = 1'b1;
        parity_type = 1'b0;
        push_byte(8'hB3);
        wait_start("b3");
        expect_frame("b3", 12'b0011_0110_0110, 10);
        chk("b3 busy end", {31'd0, tx_busy}, 32'd0);
        char_len  = 2'b11;
        parity_en = 1'b0;

        // Fill to full with transmit disabled, thresholds along the way
        tx_en = 1'b0;
        for (int i = 0; i < 16; i++) begin
            push_byte(8'(16 + i));
            if (i == 1) begin
                thr_val = 2'b10;
                #1;
                chk("thr2 lvl2", {31'd0, tx_thr}, 32'd1);
            end
            if (i == 2) chk("thr2 lvl3", {31'd0, tx_thr}, 32'd0);
            if (i == 3) begin
                thr_val = 2'b01;
                #1;
                chk("thr1 lvl4", {31'd0, tx_thr}, 32'd1);
            end
            if (i == 4) chk("thr1 lvl5", {31'd0, tx_thr}, 32'd0);
            if (i == 7) begin
                thr_val = 2'b00;
                #1;
                chk("thr0 lvl8", {31'd0, tx_thr}, 32'd1);
            end
            if (i == 8) chk("thr0 lvl9", {31'd0, tx_thr}, 32'd0);
            if (i == 14) chk("full lvl15", {31'd0, fifo_full}, 32'd0);
        end
        chk("full level", {27'd0, fifo_level}, 32'd16);
        chk("full flag", {31'd0, fifo_full}, 32'd1);
        chk("full thr", {31'd0, tx_thr}, 32'd0);
        chk("full ovf0", {31'd0, ovf}, 32'd0);
        push_byte(8'hEE);
        chk("ovf pulse", {31'd0, ovf}, 32'd1);
        chk("ovf level", {27'd0, fifo_level}, 32'd16);
        step();
        chk("ovf clear", {31'd0, ovf}, 32'd0);
        chk("ovf level2", {27'd0, fifo_level}, 32'd16);

        // Drain two frames back-to-back; head must be untouched by the dropped write
        tx_en = 1'b1;
        wait_start("f0");
        chk("f0 level", {27'd0, fifo_level}, 32'd15);
        expect_frame("f0", f8n1(8'h10), 10);
        expect_frame("f1", f8n1(8'h11), 10);
        chk("f2 level", {27'd0, fifo_level}, 32'd13);

        // Reset in the middle of the data bits
        repeat (OSR + 3) step();
        chk("mid busy", {31'd0, tx_busy}, 32'd1);
        resetn = 1'b0;
        #1;
        chk("mrst txd", {31'd0, txd}, 32'd1);
        chk("mrst level", {27'd0, fifo_level}, 32'd0);
        chk("mrst busy", {31'd0, tx_busy}, 32'd0);
        chk("mrst empty", {31'd0, tx_empty}, 32'd1);
        step();
        step();
        resetn = 1'b1;
        bad = 0;
        repeat (300) begin
            step();
            if (txd !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        chk("post rst idle", bad, 32'd0);

        // Three queued bytes go out with no gap
        tx_en = 1'b0;
        push_byte(8'hA5);
        push_byte(8'h3C);
        push_byte(8'h81);
        chk("q3 level", {27'd0, fifo_level}, 32'd3);
        tx_en = 1'b1;
        wait_start("a5");
        chk("q3 level pop", {27'd0, fifo_level}, 32'd2);
        expect_frame("a5", f8n1(8'hA5), 10);
        expect_frame("3c", f8n1(8'h3C), 10);
        expect_frame("81", f8n1(8'h81), 10);
        chk("q3 empty", {31'd0, tx_empty}, 32'd1);
        chk("q3 busy", {31'd0, tx_busy}, 32'd0);
        chk("q3 txd", {31'd0, txd}, 32'd1);

        // Break in idle holds the line low and blocks starts
        break_en = 1'b1;
        step();
        chk("brk txd", {31'd0, txd}, 32'd0);
        chk("brk bclk_en", {31'd0, tx_bclk_en}, 32'd1);
        push_byte(8'h5A);
        push_byte(8'hC3);
        bad = 0;
        repeat (50) begin
            step();
            if (txd !== 1'b0 || tx_busy !== 1'b0) bad++;
        end
        chk("brk hold", bad, 32'd0);
        chk("brk level", {27'd0, fifo_level}, 32'd2);
        break_en = 1'b0;
        step();
        chk("brk rel busy", {31'd0, tx_busy}, 32'd1);
        chk("brk rel level", {27'd0, fifo_level}, 32'd1);
        // Break raised mid-frame waits for the stop bit
        break_en = 1'b1;
        expect_frame("5a", f8n1(8'h5A), 10);
        chk("brk end busy", {31'd0, tx_busy}, 32'd0);
        chk("brk end txd", {31'd0, txd}, 32'd0);
        chk("brk end level", {27'd0, fifo_level}, 32'd1);
        break_en = 1'b0;
        step();
        chk("c3 busy", {31'd0, tx_busy}, 32'd1);
        expect_frame("c3", f8n1(8'hC3), 10);
        chk("c3 txd end", {31'd0, txd}, 32'd1);

        // Missing baud ticks stretch the bit
        push_byte(8'hF0);
        wait_start("f0s");
        bclk = 1'b0;
        bad = 0;
        repeat (40) begin
            step();
            if (txd !== 1'b0 || tx_busy !== 1'b1) bad++;
        end
        chk("stall hold", bad, 32'd0);
        bclk = 1'b1;
        expect_frame("f0s", f8n1(8'hF0), 10);
        chk("f0s busy end", {31'd0, tx_busy}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
